// File: rtl/alu_exec_ctrl.sv
// Three-state execute controller that feeds an external combinational ALU.
// Owns a small register file and a sticky zero flag, retiring one instruction every three cycles.
module alu_exec_ctrl #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done,
    output logic              illegal,
    output logic              z_flag,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]        f_op;
    logic [AW-1:0]     f_rd;
    logic [AW-1:0]     f_rs;
    logic              f_use_imm;
    logic [DATA_W-1:0] f_imm;

    assign f_op      = in_instr[15:13];
    assign f_rd      = in_instr[12:11];
    assign f_rs      = in_instr[10:9];
    assign f_use_imm = in_instr[8];
    assign f_imm     = in_instr[7:0];

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [2:0]        op_q;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic              accept;
    logic              writes_reg;
    logic              updates_flag;

    // NOP, CMP and the two illegal codes all reuse a real ALU opcode; CMP is a SUB without writeback.
    function automatic logic [2:0] decode_alu_op(input logic [2:0] op);
        if (!op[2])
            return op;
        else if (op == 3'b101)
            return 3'b001;
        else
            return 3'b000;
    endfunction

    assign accept       = in_valid && in_ready;
    assign writes_reg   = !op_q[2];
    assign updates_flag = !op_q[2] || (op_q == 3'b101);

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = EXEC;
            end
            EXEC: state_next = WB;
            WB: begin
                done       = 1'b1;
                illegal    = (op_q[2:1] == 2'b11);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: the register file sits in flops and is cleared on reset, so a debug read is never X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            z_flag <= 1'b0;
        end else begin
            if (accept) begin
                // Operands come from the pre-write register values, so rd==rs reads one value twice.
                alu_a  <= regs[f_rd];
                alu_b  <= f_use_imm ? f_imm : regs[f_rs];
                alu_op <= decode_alu_op(f_op);
                op_q   <= f_op;
                rd_q   <= f_rd;
            end
            if (state == EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
            if (state == WB) begin
                if (writes_reg)
                    regs[rd_q] <= res_q;
                if (updates_flag)
                    z_flag <= zero_q;
            end
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU attached and a queue-based scoreboard.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [15:0] in_instr;
    logic [7:0] alu_a, alu_b, alu_result, dbg_data;
    logic [2:0] alu_op;
    logic       alu_zero, done, illegal, z_flag;
    logic [1:0] dbg_addr;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .done       (done),
        .illegal    (illegal),
        .z_flag     (z_flag),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // The combinational ALU the controller drives.
    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            default: alu_result = 8'h00;
        endcase
    end
    assign alu_zero = (alu_result == 8'h00);

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] aop;
        logic [1:0] rd;
        bit         wb;
        bit         fl;
        bit         ill;
        logic [7:0] res;
        bit         z;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_regs [4];
    bit         m_z;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_acc    = 0;
    int         done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic ui,
                                       input logic [7:0] imm);
        return {op, rd, rs, ui, imm};
    endfunction

    task automatic check_state();
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            check($sformatf("reg%0d", i), dbg_data, m_regs[i]);
        end
        check("z_flag", z_flag, m_z);
    endtask

    // Present an instruction, push its expectation, and return just after the accepting edge.
    task automatic accept(input logic [15:0] instr);
        exp_t       e;
        logic [2:0] op;
        int         n;
        op       = instr[15:13];
        in_valid = 1'b1;
        in_instr = instr;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("accept_timeout", in_ready, 1);
        e.rd = instr[12:11];
        e.a  = m_regs[instr[12:11]];
        e.b  = instr[8] ? instr[7:0] : m_regs[instr[10:9]];
        case (op)
            3'd0:    begin e.aop = 3'd0; e.res = e.a + e.b; end
            3'd1:    begin e.aop = 3'd1; e.res = e.a - e.b; end
            3'd2:    begin e.aop = 3'd2; e.res = e.a & e.b; end
            3'd3:    begin e.aop = 3'd3; e.res = e.a | e.b; end
            3'd5:    begin e.aop = 3'd1; e.res = e.a - e.b; end
            default: begin e.aop = 3'd0; e.res = e.a + e.b; end
        endcase
        e.wb  = (op < 3'd4);
        e.fl  = (op < 3'd4) || (op == 3'd5);
        e.ill = (op >= 3'd6);
        e.z   = (e.res == 8'h00);
        sb.push_back(e);
        n_acc++;
        @(posedge clk);
    endtask

    // Walk the T+1 / T+2 / T+3 cycles of the accepted instruction; optionally keep in_valid asserted.
    task automatic retire(input bit hold, input logic [15:0] nxt);
        exp_t e;
        @(negedge clk);
        if (hold) in_instr = nxt;
        else      in_valid = 1'b0;
        e = sb[0];
        check("alu_a_t1", alu_a, e.a);
        check("alu_b_t1", alu_b, e.b);
        check("alu_op_t1", alu_op, e.aop);
        check("done_t1", done, 0);
        check("ready_t1", in_ready, 0);
        @(negedge clk);
        check("done_t2", done, 1);
        check("illegal_t2", illegal, e.ill);
        check("ready_t2", in_ready, 0);
        check("alu_a_hold", alu_a, e.a);
        e = sb.pop_front();
        if (e.wb) m_regs[e.rd] = e.res;
        if (e.fl) m_z = e.z;
        @(negedge clk);
        check("ready_t3", in_ready, 1);
        check("done_t3", done, 0);
        check("illegal_t3", illegal, 0);
        check_state();
    endtask

    task automatic issue(input logic [15:0] instr);
        accept(instr);
        retire(1'b0, 16'h0000);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        dbg_addr = 2'd0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_z = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", in_ready, 1);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check_state();

        // ADD imm, then build 0xFF and wrap around
        issue(mk(3'd0, 2'd1, 2'd0, 1'b1, 8'h05));
        issue(mk(3'd0, 2'd1, 2'd0, 1'b1, 8'hFA));
        issue(mk(3'd0, 2'd1, 2'd0, 1'b1, 8'h01));
        check("wrap_reg1", m_regs[1], 8'h00);
        check("wrap_z", z_flag, 1);
        issue(mk(3'd1, 2'd1, 2'd0, 1'b1, 8'h01));
        check("under_z", z_flag, 0);

        // CMP leaves registers alone but sets Z; NOP keeps Z
        issue(mk(3'd0, 2'd2, 2'd0, 1'b1, 8'h3C));
        issue(mk(3'd5, 2'd2, 2'd0, 1'b1, 8'h3C));
        check("cmp_z", z_flag, 1);
        issue(mk(3'd4, 2'd2, 2'd0, 1'b1, 8'h11));
        check("nop_z", z_flag, 1);

        // Illegal codes pulse illegal with done and change nothing
        issue(mk(3'd6, 2'd1, 2'd0, 1'b1, 8'h22));
        issue(mk(3'd7, 2'd2, 2'd1, 1'b0, 8'h00));

        // Register-register operations, including rd==rs
        issue(mk(3'd2, 2'd1, 2'd2, 1'b0, 8'h00));
        issue(mk(3'd3, 2'd0, 2'd1, 1'b0, 8'h00));
        issue(mk(3'd1, 2'd2, 2'd2, 1'b0, 8'h00));
        check("rdrs_z", z_flag, 1);

        // Held in_valid across EXEC/WB: second instruction waits and sees the first writeback
        accept(mk(3'd0, 2'd3, 2'd0, 1'b1, 8'h10));
        retire(1'b1, mk(3'd0, 2'd3, 2'd3, 1'b0, 8'h00));
        accept(mk(3'd0, 2'd3, 2'd3, 1'b0, 8'h00));
        retire(1'b0, 16'h0000);
        check("hold_reg3", m_regs[3], 8'h20);
        check("retire_count", done_cnt, n_acc);

        // Reset during EXEC aborts the instruction
        accept(mk(3'd0, 2'd3, 2'd0, 1'b1, 8'h07));
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_done", done, 0);
        check("abort_ready", in_ready, 1);
        rst = 1'b0;
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_z = 1'b0;
        @(negedge clk);
        check("abort_done2", done, 0);
        check("abort_alu_a", alu_a, 0);
        check_state();
        check("abort_retires", done_cnt, n_acc - 1);

        // Controller works normally after the abort
        issue(mk(3'd0, 2'd0, 2'd0, 1'b1, 8'h00));
        check("post_rst_z", z_flag, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
